// File: rtl/seg_scan_ctrl_if.sv
// CPU data-bus view of the seven-segment scan controller: address, write data,
// write strobe from the CPU and combinational read-back to it.
interface seg_scan_ctrl_if;
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] rdata;

    modport master (
        output addressM,
        output outM,
        output writeM,
        input  rdata
    );

    modport slave (
        input  addressM,
        input  outM,
        input  writeM,
        output rdata
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: three CPU-writable registers,
// slot-based digit multiplexing with leading blanking and hex encoding.
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter logic [15:0] BASE_ADDR    = 16'h4000
) (
    input  logic                  clock,
    input  logic                  reset,
    seg_scan_ctrl_if.slave        bus,
    output logic [7:0]            sel,
    output logic [7:0]            data,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
    localparam logic [15:0] ADDR_R0 = BASE_ADDR;
    localparam logic [15:0] ADDR_R1 = BASE_ADDR + 16'd1;
    localparam logic [15:0] ADDR_R2 = BASE_ADDR + 16'd2;

    logic [15:0]      r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       snap_nib_q, snap_nib_d;
    logic             snap_en_q, snap_en_d;
    logic             snap_dp_q, snap_dp_d;
    logic [7:0]       sel_q, sel_d, data_q, data_d;
    logic             frame_tick_q, frame_tick_d;

    logic [31:0] digits;
    logic [7:0]  dp_mask;
    logic        cnt_wrap;
    logic        lit;

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'h0: seg_of = 7'h3F;  4'h1: seg_of = 7'h06;
            4'h2: seg_of = 7'h5B;  4'h3: seg_of = 7'h4F;
            4'h4: seg_of = 7'h66;  4'h5: seg_of = 7'h6D;
            4'h6: seg_of = 7'h7D;  4'h7: seg_of = 7'h07;
            4'h8: seg_of = 7'h7F;  4'h9: seg_of = 7'h6F;
            4'hA: seg_of = 7'h77;  4'hB: seg_of = 7'h7C;
            4'hC: seg_of = 7'h39;  4'hD: seg_of = 7'h5E;
            4'hE: seg_of = 7'h79;  default: seg_of = 7'h71;
        endcase
    endfunction

    always_comb begin
        bus.rdata = 16'h0000;
        if (bus.addressM == ADDR_R0)      bus.rdata = r0_q;
        else if (bus.addressM == ADDR_R1) bus.rdata = r1_q;
        else if (bus.addressM == ADDR_R2) bus.rdata = r2_q;
    end

    always_comb begin
        r0_d = r0_q;
        r1_d = r1_q;
        r2_d = r2_q;
        if (bus.writeM) begin
            if (bus.addressM == ADDR_R0)      r0_d = bus.outM;
            else if (bus.addressM == ADDR_R1) r1_d = bus.outM;
            else if (bus.addressM == ADDR_R2) r2_d = bus.outM;
        end
    end

    // At cnt==0 the live register contents are used directly, so the first
    // cycle of a slot already agrees with the snapshot taken on that edge.
    always_comb begin
        digits   = {r1_q, r0_q};
        dp_mask  = r2_q[15:8];
        cnt_wrap = (cnt_q == CNT_MAX);
        cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d    = cnt_wrap ? idx_q + 3'd1 : idx_q;

        snap_nib_d = snap_nib_q;
        snap_en_d  = snap_en_q;
        snap_dp_d  = snap_dp_q;
        if (cnt_q == '0) begin
            snap_nib_d = digits[{idx_q, 2'b00} +: 4];
            snap_en_d  = r2_q[idx_q];
            snap_dp_d  = dp_mask[idx_q];
        end

        lit          = (cnt_q >= BLANK_C) && snap_en_d;
        sel_d        = lit ? ~(8'b1 << idx_q) : 8'hFF;
        data_d       = lit ? {~snap_dp_d, ~seg_of(snap_nib_d)} : 8'hFF;
        frame_tick_d = cnt_wrap && (idx_q == 3'd7);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r0_q         <= 16'h0000;
            r1_q         <= 16'h0000;
            r2_q         <= 16'h000F;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            snap_nib_q   <= 4'h0;
            snap_en_q    <= 1'b0;
            snap_dp_q    <= 1'b0;
            sel_q        <= 8'hFF;
            data_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            r0_q         <= r0_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_nib_q   <= snap_nib_d;
            snap_en_q    <= snap_en_d;
            snap_dp_q    <= snap_dp_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign data       = data_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-indexed display model predicts
// every cycle's outputs and read-back; a monitor pops and compares them.
module tb_seg_scan_ctrl;

    localparam int SD    = 8;
    localparam int BLANK = 2;
    localparam logic [15:0] BASE = 16'h4000;

    typedef struct {
        logic [7:0]  sel;
        logic [7:0]  data;
        logic        tick;
        logic [15:0] rdata;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [7:0] sel;
    logic [7:0] data;
    logic       frame_tick;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BLANK),
        .BASE_ADDR    (BASE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .sel        (sel),
        .data       (data),
        .frame_tick (frame_tick)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    exp_t        exp_q[$];
    int          check_count = 0;
    int          pass_count  = 0;
    int          cycle_no    = 0;

    logic [6:0]  enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0] model_reg [3];
    int          model_t;
    int          snap_nib [8];
    bit          snap_en  [8];
    bit          snap_dp  [8];

    function automatic int cur_cnt();
        return model_t % SD;
    endfunction

    function automatic int cur_digit();
        return (model_t / SD) % 8;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle_no, actual, expected);
        else
            pass_count++;
    endtask

    // One bus cycle: drive inputs, advance the model by one clock, queue the
    // outputs the DUT must show right after the coming edge.
    task automatic applyStimulus(input logic rst, input logic we,
                                 input logic [15:0] addr, input logic [15:0] wd);
        exp_t e;
        int   cnt, dig, off;
        bit   lit;
        @(negedge clock);
        reset        = rst;
        bus.writeM   = we;
        bus.addressM = addr;
        bus.outM     = wd;
        if (rst) begin
            model_reg[0] = 16'h0000;
            model_reg[1] = 16'h0000;
            model_reg[2] = 16'h000F;
            model_t      = 0;
            e.sel  = 8'hFF;
            e.data = 8'hFF;
            e.tick = 1'b0;
        end else begin
            cnt = cur_cnt();
            dig = cur_digit();
            if (cnt == 0) begin
                snap_nib[dig] = int'((({model_reg[1], model_reg[0]}) >> (4 * dig)) & 32'hF);
                snap_en[dig]  = model_reg[2][dig];
                snap_dp[dig]  = model_reg[2][8 + dig];
            end
            lit    = (cnt >= BLANK) && snap_en[dig];
            e.sel  = lit ? ~(8'(1) << dig) : 8'hFF;
            e.data = lit ? ~{snap_dp[dig], enc_tab[snap_nib[dig]]} : 8'hFF;
            e.tick = (cnt == SD - 1) && (dig == 7);
            if (we && addr >= BASE && addr <= BASE + 16'd2)
                model_reg[addr - BASE] = wd;
            model_t++;
        end
        off     = int'(addr) - int'(BASE);
        e.rdata = (off >= 0 && off <= 2) ? model_reg[off] : 16'h0000;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = BASE - 16'd1 + 16'($urandom_range(0, 4));
            applyStimulus(1'b0, 1'b0, a, 16'($urandom));
        end
    endtask

    task automatic run_to(input int dig, input int cnt);
        for (int i = 0; i < 8 * SD + 1 && !(cur_digit() == dig && cur_cnt() == cnt); i++)
            idle(1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sel",        {8'h00, sel},         {8'h00, e.sel});
                checkOutput("data",       {8'h00, data},        {8'h00, e.data});
                checkOutput("frame_tick", {15'h0, frame_tick},  {15'h0, e.tick});
                checkOutput("rdata",      bus.rdata,            e.rdata);
            end
        end
    end

    initial begin
        logic [15:0] a;
        int          r;
        reset        = 1'b1;
        bus.writeM   = 1'b0;
        bus.addressM = 16'h0000;
        bus.outM     = 16'h0000;
        model_t      = 0;
        model_reg[0] = 16'h0000;
        model_reg[1] = 16'h0000;
        model_reg[2] = 16'h000F;
        for (int i = 0; i < 8; i++) begin
            snap_nib[i] = 0;
            snap_en[i]  = 1'b0;
            snap_dp[i]  = 1'b0;
        end

        $display("[TB] reset and idle frame");
        applyStimulus(1'b1, 1'b0, BASE, 16'h0000);
        applyStimulus(1'b1, 1'b0, BASE, 16'h0000);
        idle(2 * 8 * SD + 4);

        $display("[TB] digit values and full enable");
        applyStimulus(1'b0, 1'b1, BASE,          16'h1234);
        applyStimulus(1'b0, 1'b1, BASE + 16'd2,  16'h00FF);
        applyStimulus(1'b0, 1'b1, BASE + 16'd1,  16'hABCD);
        idle(8 * SD + 8);

        $display("[TB] mid-slot write on digit 0");
        run_to(0, 4);
        applyStimulus(1'b0, 1'b1, BASE, 16'h5679);
        idle(8 * SD + 8);

        $display("[TB] single digit with decimal point");
        applyStimulus(1'b0, 1'b1, BASE,         16'h0008);
        applyStimulus(1'b0, 1'b1, BASE + 16'd2, 16'h0101);
        idle(8 * SD + 8);

        $display("[TB] out-of-window write and write during reset");
        applyStimulus(1'b0, 1'b1, BASE + 16'd3, 16'hFFFF);
        applyStimulus(1'b0, 1'b0, BASE + 16'd3, 16'h0000);
        applyStimulus(1'b1, 1'b1, BASE,         16'hBEEF);
        applyStimulus(1'b0, 1'b0, BASE,         16'h0000);
        idle(8);

        $display("[TB] reset mid-scan at digit 5");
        applyStimulus(1'b0, 1'b1, BASE + 16'd2, 16'h00FF);
        run_to(5, 4);
        applyStimulus(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
        idle(2 * SD + 4);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 199);
            a = (r % 7 == 6) ? 16'($urandom) : BASE - 16'd1 + 16'($urandom_range(0, 4));
            applyStimulus(r == 0, $urandom_range(0, 3) == 0, a, 16'($urandom));
        end

        @(negedge clock);
        @(negedge clock);
        check_count++;
        if (exp_q.size() != 0)
            $display("[TB] FAIL scoreboard drain: got %0d entries left expected 0", exp_q.size());
        else
            pass_count++;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
